phy_freelist: RTL and testbench
===============================

Name: phy_freelist

Overview:
- Physical-register free list feeding the 4-wide dispatch stage.
- Supplies DS_InstN_Phy tags to the rename/dependency-resolution logic for up to 4 destination-writing instructions per cycle.
- Reclaims old tags from retirement, up to 4 per cycle.
- Restores speculative allocations on pipeline flush using a committed-head pointer.

Parameters:
- TAG_W, 6, physical tag width (64 physical registers).
- NUM_ARCH, 32, architectural registers; tags 0..NUM_ARCH-1 are mapped at reset.
- DEPTH, 32, free-list entries (NUM_PHY - NUM_ARCH).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- DS_Alloc_Req  in  4  bit i = instruction i+1 needs a destination tag (nonzero Rdst)
- DS_Alloc_Ready  out  1  allocation for all requested slots can be granted this cycle
- DS_Inst1_Phy, DS_Inst2_Phy, DS_Inst3_Phy, DS_Inst4_Phy  out  TAG_W each  allocated tag per slot; valid only where the Req bit is set and Ready=1
- DS_Alloc_Fire  in  1  dispatch consumes the allocation; legal only when Ready=1
- RT_Free_Valid  in  4  retire slot i frees an old tag and commits its new tag
- RT_Free_Tag1, RT_Free_Tag2, RT_Free_Tag3, RT_Free_Tag4  in  TAG_W each  old physical tags being freed
- Flush  in  1  squash all speculative allocations
- Free_Count  out  log2(DEPTH)+1  current free entries (tail - head)
- Overflow_Err  out  1  sticky: a free was attempted with the list full

Behaviour:
- Storage: DEPTH x TAG_W circular array.
- Pointers: head, tail and commit_head, each log2(DEPTH)+1 bits wide with a wrap bit; count = tail - head.
- Reset:
  - entry[i] = NUM_ARCH + i
  - head = 0, commit_head = 0, tail = DEPTH (list full)
  - Overflow_Err = 0
  - while rst is high, DS_Alloc_Ready = 0 and all Phy outputs = 0
- Allocation (combinational from current state, zero latency):
  - n_alloc = popcount(DS_Alloc_Req)
  - Ready = (count >= n_alloc) and not Flush and not rst
  - Req = 0 gives Ready = 1
  - Slot i gets entry[head + popcount(Req[i-1:0])], so tags are compacted in slot order.
  - Unrequested slots drive the tag they would have received; it is don't-care, and the bench must not check it.
- All-or-nothing: no partial grants.
- On a clock edge with Fire and Ready: head += n_alloc.
- Fire with Ready = 0 is ignored.
- Free (registered, lands next cycle):
  - n_free = popcount(RT_Free_Valid)
  - Valid tags are written compacted at entry[tail], entry[tail+1], ... in slot order
  - tail += n_free; commit_head += n_free
- Same-cycle alloc and free:
  - Both take effect on the same edge.
  - Ready uses the pre-edge count only; there is no bypass of same-cycle frees to allocation.
- Flush:
  - On the edge, retirement of that cycle is applied first, then head = the updated commit_head.
  - Fire is ignored on a Flush cycle and Ready = 0 during Flush.
  - count becomes tail - commit_head.
- Wrap-around: index = ptr[log2(DEPTH)-1:0]. Full means the pointers differ only in the wrap bit; empty means they are equal.
- Overflow:
  - If count + n_free > DEPTH (excluding the allocations from the same edge), Overflow_Err is set and held until rst.
  - The free is still applied; results are undefined past this point.
- Invariant: count never exceeds DEPTH. The bench asserts this.
- Reset mid-operation overrides Fire, Flush and Free on that edge.

Decomposition:
- Shared package (with dispatch/rename):
  - TAG_W, NUM_ARCH, NUM_PHY, DEPTH
  - PTR_W = $clog2(DEPTH)+1
  - tag_t, ptr_t typedefs
- Sub-module slot_prefix4:
  - input: 4-bit mask
  - outputs: exclusive prefix counts for slots 0..3 (2 bits each) plus the total (3 bits)
  - one instance each for alloc and free

Test Plan:
- Reset then Req=4'b1111, Fire -> Phy1..4 = 32, 33, 34, 35; Free_Count 32->28 next cycle.
- Req=4'b1010 at head = 4 -> Phy2 = 36, Phy4 = 37, Ready = 1; after Fire, Free_Count drops by 2.
- Drain to count = 2, then Req=4'b0111 -> Ready = 0. Fire that cycle leaves head unchanged. Req=4'b0011 -> Ready = 1.
- Allocate 8, retire RT_Free_Valid=4'b0101 with tags 5, 9 -> tags 5, 9 land at entry[tail], entry[tail+1]; Free_Count +2. Later, after wrap-around, allocation returns 5 then 9.
- Allocate 12 (commit_head = 0), retire 4 in the same cycle as Flush -> head = 4, Free_Count = 32; the next allocation yields entry[4] onward.
- At full list, RT_Free_Valid = 4'b0001 -> Overflow_Err = 1 next cycle and stays 1 until rst; rst then restores Free_Count = 32 and Phy1 = 32.

Source files
------------

// File: rtl/phy_freelist_pkg.sv
// Shared rename/dispatch definitions: physical tag geometry and free-list pointer types.
// Pointers carry one extra wrap bit above the array index.
package phy_freelist_pkg;

  localparam int TAG_W    = 6;
  localparam int NUM_ARCH = 32;
  localparam int NUM_PHY  = 64;
  localparam int DEPTH    = NUM_PHY - NUM_ARCH;
  localparam int IDX_W    = $clog2(DEPTH);
  localparam int PTR_W    = IDX_W + 1;
  localparam int SLOTS    = 4;

  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [PTR_W-1:0] ptr_t;

  // Number of set bits of m strictly below bit position n.
  function automatic logic [2:0] ones_below(input logic [3:0] m, input int n);
    logic [2:0] c;
    c = '0;
    for (int k = 0; k < 4; k++) begin
      if (k < n) c = c + {2'b00, m[k]};
    end
    return c;
  endfunction

endpackage

// File: rtl/slot_prefix4.sv
// Exclusive prefix popcount of a 4-slot mask; used to compact active slots
// onto consecutive free-list positions.
module slot_prefix4
  import phy_freelist_pkg::*;
(
  input  logic [3:0]      i_mask,
  output logic [3:0][1:0] o_prefix,
  output logic [2:0]      o_total
);

  logic [2:0] w_below [4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_slot
      assign w_below[gi]  = ones_below(i_mask, gi);
      assign o_prefix[gi] = w_below[gi][1:0];
    end
  endgenerate

  assign o_total = ones_below(i_mask, 4);

endmodule

// File: rtl/phy_freelist.sv
// Physical-register free list: 4-wide compacted allocation, 4-wide reclaim,
// and flush recovery back to the committed head.
module phy_freelist
  import phy_freelist_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         DS_Alloc_Req,
  output logic               DS_Alloc_Ready,
  output logic [TAG_W-1:0]   DS_Inst1_Phy,
  output logic [TAG_W-1:0]   DS_Inst2_Phy,
  output logic [TAG_W-1:0]   DS_Inst3_Phy,
  output logic [TAG_W-1:0]   DS_Inst4_Phy,
  input  logic               DS_Alloc_Fire,
  input  logic [3:0]         RT_Free_Valid,
  input  logic [TAG_W-1:0]   RT_Free_Tag1,
  input  logic [TAG_W-1:0]   RT_Free_Tag2,
  input  logic [TAG_W-1:0]   RT_Free_Tag3,
  input  logic [TAG_W-1:0]   RT_Free_Tag4,
  input  logic               Flush,
  output logic [PTR_W-1:0]   Free_Count,
  output logic               Overflow_Err
);

  tag_t r_entry [DEPTH];
  ptr_t r_head;
  ptr_t r_tail;
  ptr_t r_commit_head;
  logic r_overflow;

  logic [3:0][1:0] w_alloc_pre;
  logic [3:0][1:0] w_free_pre;
  logic [2:0]      w_n_alloc;
  logic [2:0]      w_n_free;
  ptr_t            w_count;
  ptr_t            w_commit_next;
  logic            w_ready;
  logic            w_fire;
  logic            w_over;
  tag_t            w_slot_tag [SLOTS];
  tag_t            w_free_tag [SLOTS];
  logic [IDX_W-1:0] w_wr_idx  [SLOTS];

  slot_prefix4 u_alloc_prefix (
    .i_mask   (DS_Alloc_Req),
    .o_prefix (w_alloc_pre),
    .o_total  (w_n_alloc)
  );

  slot_prefix4 u_free_prefix (
    .i_mask   (RT_Free_Valid),
    .o_prefix (w_free_pre),
    .o_total  (w_n_free)
  );

  assign w_count       = r_tail - r_head;
  assign w_commit_next = r_commit_head + ptr_t'(w_n_free);
  // Same-cycle frees are deliberately not bypassed into the grant decision.
  assign w_ready       = (ptr_t'(w_n_alloc) <= w_count) && !Flush && !rst;
  assign w_fire        = DS_Alloc_Fire && w_ready;
  assign w_over        = ({1'b0, w_count} + (PTR_W+1)'(w_n_free)) > (PTR_W+1)'(DEPTH);

  assign w_free_tag[0] = RT_Free_Tag1;
  assign w_free_tag[1] = RT_Free_Tag2;
  assign w_free_tag[2] = RT_Free_Tag3;
  assign w_free_tag[3] = RT_Free_Tag4;

  generate
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_port
      ptr_t w_rd_ptr;
      ptr_t w_wr_ptr;
      assign w_rd_ptr       = r_head + ptr_t'(w_alloc_pre[gi]);
      assign w_wr_ptr       = r_tail + ptr_t'(w_free_pre[gi]);
      assign w_wr_idx[gi]   = w_wr_ptr[IDX_W-1:0];
      assign w_slot_tag[gi] = rst ? '0 : r_entry[w_rd_ptr[IDX_W-1:0]];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_entry[k] <= tag_t'(NUM_ARCH + k);
      end
      r_head        <= '0;
      r_commit_head <= '0;
      r_tail        <= ptr_t'(DEPTH);
      r_overflow    <= 1'b0;
    end else begin
      for (int k = 0; k < SLOTS; k++) begin
        if (RT_Free_Valid[k]) r_entry[w_wr_idx[k]] <= w_free_tag[k];
      end
      r_tail        <= r_tail + ptr_t'(w_n_free);
      r_commit_head <= w_commit_next;
      // Flush rewinds to the commit point that already includes this cycle's retirement.
      if (Flush) begin
        r_head <= w_commit_next;
      end else if (w_fire) begin
        r_head <= r_head + ptr_t'(w_n_alloc);
      end
      if (w_over) r_overflow <= 1'b1;
    end
  end

  assign DS_Alloc_Ready = w_ready;
  assign DS_Inst1_Phy   = w_slot_tag[0];
  assign DS_Inst2_Phy   = w_slot_tag[1];
  assign DS_Inst3_Phy   = w_slot_tag[2];
  assign DS_Inst4_Phy   = w_slot_tag[3];
  assign Free_Count     = w_count;
  assign Overflow_Err   = r_overflow;

endmodule

// File: tb/tb_phy_freelist.sv
// Bench for phy_freelist: queue-based free-list model checked every cycle,
// plus directed cycles with hand-computed literal tags and counts.
module tb_phy_freelist;

  localparam int DEPTH = 32;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       fire;
  logic [3:0] valid;
  logic [5:0] ftag [4];
  logic       flush;

  logic       ready;
  logic [5:0] p1, p2, p3, p4;
  logic [5:0] fcount;
  logic       ovf;
  logic [5:0] phy [4];

  int checks = 0;
  int errors = 0;

  // Model: fl = free tags in allocation order; spec = allocated but not yet committed.
  int fl[$];
  int spec[$];
  bit m_ovf;
  bit m_undef;
  bit have_state = 0;

  phy_freelist dut (
    .clk           (clk),
    .rst           (rst),
    .DS_Alloc_Req  (req),
    .DS_Alloc_Ready(ready),
    .DS_Inst1_Phy  (p1),
    .DS_Inst2_Phy  (p2),
    .DS_Inst3_Phy  (p3),
    .DS_Inst4_Phy  (p4),
    .DS_Alloc_Fire (fire),
    .RT_Free_Valid (valid),
    .RT_Free_Tag1  (ftag[0]),
    .RT_Free_Tag2  (ftag[1]),
    .RT_Free_Tag3  (ftag[2]),
    .RT_Free_Tag4  (ftag[3]),
    .Flush         (flush),
    .Free_Count    (fcount),
    .Overflow_Err  (ovf)
  );

  always_comb begin
    phy[0] = p1;
    phy[1] = p2;
    phy[2] = p3;
    phy[3] = p4;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_ready();
    return (fl.size() >= $countones(req)) && !flush;
  endfunction

  // Model update on each active edge, using the inputs held across it.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        fl.delete();
        spec.delete();
        for (int i = 0; i < DEPTH; i++) fl.push_back(32 + i);
        m_ovf = 0;
        m_undef = 0;
        have_state = 1;
      end else if (have_state) begin
        int na;
        int nf;
        bit rdy;
        na  = $countones(req);
        nf  = $countones(valid);
        rdy = model_ready();
        if (fl.size() + nf > DEPTH) begin
          m_ovf = 1;
          m_undef = 1;
        end
        if (!m_undef) begin
          if (rdy && fire) begin
            for (int i = 0; i < na; i++) spec.push_back(fl.pop_front());
          end
          for (int k = 0; k < 4; k++) begin
            if (valid[k]) fl.push_back(int'(ftag[k]));
          end
          for (int i = 0; i < nf; i++) begin
            if (spec.size() > 0) void'(spec.pop_front());
          end
          if (flush) begin
            while (spec.size() > 0) fl.push_front(spec.pop_back());
          end
        end
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        check("rst_ready", {31'b0, ready}, 0);
        for (int k = 0; k < 4; k++) check($sformatf("rst_phy%0d", k + 1), {26'b0, phy[k]}, 0);
      end else if (have_state) begin
        check("ovf", {31'b0, ovf}, {31'b0, m_ovf});
        if (!m_undef) begin
          bit er;
          int idx;
          er = model_ready();
          check("ready", {31'b0, ready}, {31'b0, er});
          check("free_count", {26'b0, fcount}, fl.size());
          assert (fcount <= DEPTH) else begin
            errors++;
            $display("FAIL count_invariant actual=%0d required<=%0d", fcount, DEPTH);
          end
          checks++;
          if (er) begin
            idx = 0;
            for (int k = 0; k < 4; k++) begin
              if (req[k]) begin
                check($sformatf("phy%0d", k + 1), {26'b0, phy[k]}, fl[idx]);
                idx++;
              end
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req = 0; fire = 0; valid = 0; flush = 0;
    for (int k = 0; k < 4; k++) ftag[k] = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    step();
    @(negedge clk);
    check("lit_rst_ready", {31'b0, ready}, 0);
    check("lit_rst_phy1", {26'b0, p1}, 0);
    step();
    rst = 0;
  endtask

  task automatic alloc4(input int n);
    for (int i = 0; i < n; i++) begin
      idle(); req = 4'b1111; fire = 1;
      step();
    end
  endtask

  initial begin
    idle();
    rst = 1;
    do_reset();

    // Reset state and first full-width allocation.
    idle();
    @(negedge clk);
    check("lit_count_reset", {26'b0, fcount}, 32);
    check("lit_ready_noreq", {31'b0, ready}, 1);
    step();
    req = 4'b1111; fire = 1;
    @(negedge clk);
    check("lit_p1", {26'b0, p1}, 32);
    check("lit_p2", {26'b0, p2}, 33);
    check("lit_p3", {26'b0, p3}, 34);
    check("lit_p4", {26'b0, p4}, 35);
    step();
    idle(); req = 4'b1010; fire = 1;
    @(negedge clk);
    check("lit_count_28", {26'b0, fcount}, 28);
    check("lit_sparse_p2", {26'b0, p2}, 36);
    check("lit_sparse_p4", {26'b0, p4}, 37);
    check("lit_sparse_ready", {31'b0, ready}, 1);
    step();
    idle();
    @(negedge clk);
    check("lit_count_26", {26'b0, fcount}, 26);
    step();

    // Drain to two entries, then an oversized request must be refused.
    alloc4(6);
    idle(); req = 4'b0111; fire = 1;
    @(negedge clk);
    check("lit_count_2", {26'b0, fcount}, 2);
    check("lit_short_ready", {31'b0, ready}, 0);
    step();
    idle(); req = 4'b0011; fire = 1;
    @(negedge clk);
    check("lit_count_hold", {26'b0, fcount}, 2);
    check("lit_fit_ready", {31'b0, ready}, 1);
    check("lit_fit_p1", {26'b0, p1}, 62);
    check("lit_fit_p2", {26'b0, p2}, 63);
    step();

    // Empty list: a free in the same cycle must not enable allocation.
    idle(); req = 4'b0001; fire = 1;
    valid = 4'b0101; ftag[0] = 5; ftag[1] = 17; ftag[2] = 9;
    @(negedge clk);
    check("lit_count_0", {26'b0, fcount}, 0);
    check("lit_nobypass_ready", {31'b0, ready}, 0);
    step();
    idle(); req = 4'b0011; fire = 1;
    @(negedge clk);
    check("lit_count_freed", {26'b0, fcount}, 2);
    check("lit_wrap_p1", {26'b0, p1}, 5);
    check("lit_wrap_p2", {26'b0, p2}, 9);
    step();
    idle();
    step();

    // Flush with same-cycle retirement of four.
    do_reset();
    alloc4(3);
    idle(); req = 4'b1111; fire = 1; flush = 1;
    valid = 4'b1111; ftag[0] = 1; ftag[1] = 2; ftag[2] = 3; ftag[3] = 4;
    @(negedge clk);
    check("lit_flush_ready", {31'b0, ready}, 0);
    check("lit_count_20", {26'b0, fcount}, 20);
    step();
    idle(); req = 4'b1111; fire = 1;
    @(negedge clk);
    check("lit_flush_count", {26'b0, fcount}, 32);
    check("lit_flush_p1", {26'b0, p1}, 36);
    check("lit_flush_p4", {26'b0, p4}, 39);
    step();

    // Mixed traffic, kept legal: retirement never exceeds outstanding or free space.
    for (int c = 0; c < 80; c++) begin
      int nmax;
      int cnt;
      logic [3:0] r;
      idle();
      req  = 4'($urandom);
      fire = ($urandom_range(0, 3) != 0);
      nmax = spec.size();
      if (DEPTH - fl.size() < nmax) nmax = DEPTH - fl.size();
      r = 4'($urandom);
      cnt = 0;
      for (int k = 0; k < 4; k++) begin
        ftag[k] = 6'($urandom_range(0, 63));
        if (r[k] && cnt < nmax) begin
          valid[k] = 1;
          cnt++;
        end
      end
      flush = ($urandom_range(0, 9) == 0);
      step();
    end

    // Overflow: free into a full list, sticky until reset.
    do_reset();
    idle(); valid = 4'b0001; ftag[0] = 1;
    @(negedge clk);
    check("lit_ovf_before", {31'b0, ovf}, 0);
    step();
    idle();
    @(negedge clk);
    check("lit_ovf_set", {31'b0, ovf}, 1);
    step();
    @(negedge clk);
    check("lit_ovf_sticky", {31'b0, ovf}, 1);
    step();
    do_reset();
    idle(); req = 4'b0001;
    @(negedge clk);
    check("lit_ovf_cleared", {31'b0, ovf}, 0);
    check("lit_count_after_rst", {26'b0, fcount}, 32);
    check("lit_p1_after_rst", {26'b0, p1}, 32);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
